uart_hamming_transmitter: RTL and testbench

- UART transmit side paired with the team's Hamming(7,4) UART receiver.
- Accepts 4-bit data nibbles over a valid/ready handshake and Hamming(7,4)-encodes them.
- Serialises each 7-bit codeword as: 1 start bit (low), 7 data bits LSB first, 1 stop bit (high), with CLKS_PER_BIT clocks per bit.
- A one-entry holding buffer lets the next nibble be accepted while a frame is on the line, so frames go out back-to-back.

---
 rtl/uart_hamming_transmitter.sv | 142 ++++++++++++++
 tb/tb_uart_hamming_transmitter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hamming_transmitter.sv
// Hamming(7,4) encoder driving a UART line: start, 7 code bits LSB first, stop.
// A one-entry holding buffer lets the next nibble queue up during a frame.
module uart_hamming_transmitter #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic [1:0] state_out
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic            tx_q, tx_d;
  logic            hold_valid_q, hold_valid_d;
  logic [3:0]      hold_q, hold_d;
  logic [6:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic            xfer;
  logic            last_cnt;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  assign data_ready = ena & ~hold_valid_q;
  assign xfer       = data_valid & data_ready;
  assign last_cnt   = (clk_cnt_q == LAST);

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    clk_cnt_d    = clk_cnt_q;
    // xfer needs an empty buffer, so it never collides with a load below
    if (xfer) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
    end
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (hold_valid_q) begin
            shift_d      = encode(hold_q);
            hold_valid_d = 1'b0;
            clk_cnt_d    = '0;
            state_d      = START;
            tx_d         = 1'b0;
          end
        end
        START: begin
          if (last_cnt) begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = DATA;
            tx_d      = shift_q[0];
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (last_cnt) begin
            clk_cnt_d = '0;
            if (bit_cnt_q == 3'd6) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              shift_d   = {1'b0, shift_q[6:1]};
              bit_cnt_d = bit_cnt_q + 1'b1;
              tx_d      = shift_q[1];
            end
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (last_cnt) begin
            clk_cnt_d = '0;
            if (hold_valid_q) begin
              shift_d      = encode(hold_q);
              hold_valid_d = 1'b0;
              state_d      = START;
              tx_d         = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tx_q         <= 1'b1;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      clk_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      clk_cnt_q    <= clk_cnt_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign state_out = state_q;

endmodule

// File: tb/tb_uart_hamming_transmitter.sv
// Bench for uart_hamming_transmitter: directed and random frames
// compared clock by clock against a position-based Hamming line model.
module tb_uart_hamming_transmitter;

  localparam int CPB = 8;
  localparam int FR  = 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic [1:0] state_out;

  int checks = 0;
  int errors = 0;

  uart_hamming_transmitter #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx        (tx),
    .busy      (busy),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Codeword bit i sits at Hamming position i+1; parity bits at powers of 2
  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [6:0] c;
    int di;
    c  = '0;
    di = 0;
    for (int p = 1; p <= 7; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[di];
        di++;
      end
    for (int p = 1; p <= 4; p = p * 2)
      for (int q = 1; q <= 7; q++)
        if ((q & p) != 0 && q != p) c[p-1] = c[p-1] ^ c[q-1];
    return c;
  endfunction

  function automatic int syndrome(input logic [6:0] c);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++)
      if (c[i]) s = s ^ (i + 1);
    return s;
  endfunction

  function automatic logic fbit(input logic [6:0] c, input int pos);
    int idx;
    idx = pos / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 8) return 1'b1;
    return c[idx-1];
  endfunction

  // mode 0: single frame; 1: second nibble queued during frame;
  // 2: second nibble offered on the final stop edge
  task automatic run(input logic [3:0] a, input logic [3:0] b,
                     input int mode, input int dis_at,
                     input int dis_len,
                     output logic [6:0] rx0, output logic [6:0] rx1,
                     output int cyc);
    int n, s2, last, f, pos, idx;
    logic [6:0] ca, cb;
    logic etx, ebusy, erdy, pend;
    logic [1:0] est;
    ca   = ref_enc(a);
    cb   = ref_enc(b);
    s2   = (mode == 1) ? FR + 1 : FR + 2;
    last = (mode == 0) ? FR : s2 + FR - 1;
    rx0  = '0;
    rx1  = '0;
    ena        = 1'b1;
    data_in    = a;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = (mode == 1);
    data_in    = b;
    chk("hs_tx", tx, 1);
    chk("hs_rdy", data_ready, 0);
    n   = 0;
    cyc = 0;
    while (n <= last && cyc < 4 * FR) begin
      if (mode == 2 && n == FR) data_valid = 1'b1;
      ena = !(cyc >= dis_at && cyc < dis_at + dis_len);
      @(posedge clk);
      #1;
      cyc++;
      if (ena) n++;
      if (mode == 1 && n >= 2) data_valid = 1'b0;
      if (mode == 2 && n == FR + 1) data_valid = 1'b0;
      @(negedge clk);
      f   = -1;
      pos = 0;
      if (n >= 1 && n <= FR) begin
        f   = 0;
        pos = n - 1;
      end else if (mode != 0 && n >= s2 && n < s2 + FR) begin
        f   = 1;
        pos = n - s2;
      end
      if (f < 0) begin
        etx   = 1'b1;
        ebusy = 1'b0;
        est   = 2'd0;
      end else begin
        idx   = pos / CPB;
        etx   = fbit((f == 1) ? cb : ca, pos);
        ebusy = 1'b1;
        est   = (idx == 0) ? 2'd1 : (idx == 8) ? 2'd3 : 2'd2;
        if (idx >= 1 && idx <= 7 && pos % CPB == CPB / 2) begin
          if (f == 0) rx0[idx-1] = tx;
          else        rx1[idx-1] = tx;
        end
      end
      pend = (n == 0) || (mode == 1 && n >= 2 && n <= FR) ||
             (mode == 2 && n == FR + 1);
      erdy = ena && !pend;
      chk("tx", tx, etx);
      chk("busy", busy, ebusy);
      chk("state", state_out, est);
      chk("ready", data_ready, erdy);
    end
    ena = 1'b1;
  endtask

  logic [6:0] rx0, rx1;
  int cyc;
  logic [3:0] ra, rb;
  int rm;

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_out, 0);
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      chk("idle_state", state_out, 0);
      chk("idle_rdy", data_ready, 1);
    end

    run(4'b1011, 4'h0, 0, 1000, 0, rx0, rx1, cyc);
    chk("cw_1011", rx0, 7'b1010101);
    chk("len_single", cyc, FR + 1);

    for (int i = 0; i < 16; i++) begin
      run(4'(i), 4'h0, 0, 1000, 0, rx0, rx1, cyc);
      chk("sweep_cw", rx0, ref_enc(4'(i)));
      chk("sweep_syn", syndrome(rx0), 0);
      if (i == 0)  chk("cw_0", rx0, 7'h00);
      if (i == 1)  chk("cw_1", rx0, 7'b0000111);
      if (i == 15) chk("cw_f", rx0, 7'h7F);
    end

    run(4'h3, 4'hC, 1, 1000, 0, rx0, rx1, cyc);
    chk("b2b_cw0", rx0, ref_enc(4'h3));
    chk("b2b_cw1", rx1, ref_enc(4'hC));
    chk("b2b_len", cyc, 2 * FR + 1);

    run(4'h5, 4'h9, 2, 1000, 0, rx0, rx1, cyc);
    chk("late_cw0", rx0, ref_enc(4'h5));
    chk("late_cw1", rx1, ref_enc(4'h9));
    chk("late_len", cyc, 2 * FR + 2);

    run(4'b0110, 4'h0, 0, 34, 5, rx0, rx1, cyc);
    chk("ena_cw", rx0, ref_enc(4'b0110));
    chk("ena_len", cyc, FR + 1 + 5);

    for (int k = 0; k < 24; k++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rm = $urandom_range(0, 2);
      run(ra, rb, rm, $urandom_range(0, 150),
          $urandom_range(0, 6), rx0, rx1, cyc);
      chk("rnd_cw0", rx0, ref_enc(ra));
      chk("rnd_syn0", syndrome(rx0), 0);
      if (rm != 0) chk("rnd_cw1", rx1, ref_enc(rb));
    end

    data_in    = 4'h5;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in = 4'hA;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    chk("mid_state", state_out, 2);
    chk("mid_rdy", data_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_state", state_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("post_tx", tx, 1);
      chk("post_busy", busy, 0);
      chk("post_rdy", data_ready, 1);
    end

    run(4'hA, 4'h0, 0, 1000, 0, rx0, rx1, cyc);
    chk("post_cw", rx0, ref_enc(4'hA));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
